mult_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential signed multiplier core among NREQ requesters.
- Accepts operand pairs via per-requester valid/ready handshakes and drives the core's start/A/B inputs.
- Waits for core completion, then returns the 2*NB-bit product to the originating requester.
- Sits between the arithmetic clients and the single shared multiplier instance.

---
 rtl/mult_share_pkg.sv | 19 +
 rtl/mult_share_arbiter_rr_pick.sv | 31 +++
 rtl/mult_share_arbiter.sv | 130 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_share_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Timeout budget scales with operand width: a healthy core needs NB cycles.
  localparam int TMO_PER_BIT = 4;

  function automatic int prod_w(input int nb);
    return 2 * nb;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly above i_ptr, wrapping.
// Zero latency; no state, so no backpressure of its own.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_j = IDW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one sequential signed multiplier; handshake to rsp_valid is NB+3 cycles.
// Backpressure: rsp_ready low holds RESP and blocks new grants. Optional MULT_SHARE_TIMEOUT_EN adds rsp_err/TMO.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NB   = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
`ifdef MULT_SHARE_TIMEOUT_EN
  ,
  parameter int TMO  = TMO_PER_BIT * NB
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*NB-1:0]   req_a,
  input  logic [NREQ*NB-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [2*NB-1:0]      rsp_product,
  output logic                 busy,
  output logic                 mul_start,
  output logic [NB-1:0]        mul_a,
  output logic [NB-1:0]        mul_b,
  input  logic [2*NB-1:0]      mul_product,
  input  logic                 mul_ready
`ifdef MULT_SHARE_TIMEOUT_EN
  ,
  output logic                 rsp_err
`endif
);

  localparam int PROD_W = prod_w(NB);

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_idle;
  logic [NREQ-1:0] w_id_oh;
`ifdef MULT_SHARE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_idle    = (r_state == ST_IDLE);
  // Gated by rst so no accept is offered while reset is held.
  assign req_ready = (w_idle && !rst) ? w_gnt : '0;
  assign busy      = !w_idle;
  assign w_id_oh   = NREQ'(1) << r_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
`ifdef MULT_SHARE_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      rsp_err     <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            mul_a     <= req_a[int'(w_idx)*NB +: NB];
            mul_b     <= req_b[int'(w_idx)*NB +: NB];
            r_id      <= w_idx;
            r_ptr     <= w_idx;
            mul_start <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_ARM;
        // The core may still show the previous op's ready here, so it is not sampled.
        ST_ARM: begin
          r_state <= ST_WAIT;
`ifdef MULT_SHARE_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (mul_ready) begin
            rsp_product <= mul_product[PROD_W-1:0];
            rsp_valid   <= w_id_oh;
            r_state     <= ST_RESP;
          end
`ifdef MULT_SHARE_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TMO - 1)) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= w_id_oh;
            r_state     <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready[r_id]) begin
            rsp_valid <= '0;
`ifdef MULT_SHARE_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural NB-cycle sequential multiplier core.
module tb_mult_share_arbiter;

  localparam int NB   = 8;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*NB-1:0] req_a = '0;
  logic [NREQ*NB-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [2*NB-1:0]   rsp_product;
  logic              busy;
  logic              mul_start;
  logic [NB-1:0]     mul_a;
  logic [NB-1:0]     mul_b;
  logic [2*NB-1:0]   mul_product;
  logic              mul_ready;
`ifdef MULT_SHARE_TIMEOUT_EN
  logic              rsp_err;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mult_share_arbiter #(
    .NB(NB), .NREQ(NREQ), .IDW(2)
`ifdef MULT_SHARE_TIMEOUT_EN
    , .TMO(32)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready)
`ifdef MULT_SHARE_TIMEOUT_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  // Core model: ready drops the cycle after start and stays low NB cycles.
  int   core_cnt = 0;
  logic hang = 1'b0;
  wire signed [2*NB-1:0] core_p = $signed(mul_a) * $signed(mul_b);
  always @(posedge clk) begin
    if (mul_start) core_cnt <= NB;
    else if (core_cnt > 0) core_cnt <= core_cnt - 1;
  end
  assign mul_ready   = (core_cnt == 0) && !hang;
  assign mul_product = (core_cnt == 0) ? core_p : 16'hDEAD;

  int   start_cnt = 0;
  int   mon_bad   = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_start) start_cnt++;
      if (mul_start && prev_start) mon_bad++;
      if (!$onehot0(req_ready)) mon_bad++;
      if (busy && req_ready != '0) mon_bad++;
    end
    prev_start = mul_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns latency with the handshake edge counted as cycle 1.
  task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] extra, output int lat);
    int n;
    @(negedge clk);
    req_a[idx*NB +: NB] = a;
    req_b[idx*NB +: NB] = b;
    req_valid = req_valid | extra;
    req_valid[idx] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check($sformatf("grant_r%0d", idx), {31'b0, req_ready[idx]}, 32'd1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk);
    lat = 1;
    while (rsp_valid == '0 && lat < 80) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic release_rsp(input logic [3:0] rr, input string tag);
    rsp_ready = rr;
    @(posedge clk); #1;
    rsp_ready = '0;
    check({tag, "_clr"}, {27'b0, busy, rsp_valid}, 32'd0);
  endtask

  logic [3:0]  exp_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [15:0] exp_p  [5] = '{16'h0014, 16'hFFEB, 16'h3F01, 16'hC080, 16'h0014};

  initial begin
    int lat;
    int s0;
    int n;
    logic ok;

    #1;
    check("reset_ctl", {22'b0, busy, mul_start, rsp_valid, req_ready}, 32'd0);
    check("reset_dat", {mul_a, mul_b, rsp_product}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single request: 3*5
    s0 = start_cnt;
    send(0, 8'd3, 8'd5, 4'b0000, lat);
    check("t1_lat", lat, 32'd11);
    check("t1_oh", {28'b0, rsp_valid}, 32'b0001);
    check("t1_prod", {16'b0, rsp_product}, 32'h000F);
    check("t1_starts", start_cnt - s0, 32'd1);
    release_rsp(4'b0001, "t1");

    // Signed: -3*5 on requester 2, then -128*-128 on requester 1
    send(2, 8'hFD, 8'd5, 4'b0000, lat);
    check("t2_oh", {28'b0, rsp_valid}, 32'b0100);
    check("t2_prod", {16'b0, rsp_product}, 32'hFFF1);
    release_rsp(4'b0100, "t2");
    send(1, 8'h80, 8'h80, 4'b0000, lat);
    check("t3_prod", {16'b0, rsp_product}, 32'h4000);
    release_rsp(4'b0010, "t3");

    // Backpressure: non-owner rsp_ready bits and a waiting request must have no effect
    send(1, 8'h02, 8'hFF, 4'b0000, lat);
    check("t4_prod", {16'b0, rsp_product}, 32'hFFFE);
    rsp_ready = 4'b1101;
    req_a[0 +: NB] = 8'd1;
    req_b[0 +: NB] = 8'd1;
    req_valid[0] = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0010 || rsp_product !== 16'hFFFE || busy !== 1'b1 || req_ready !== 4'b0000)
        ok = 1'b0;
    end
    check("t4_stall_stable", {31'b0, ok}, 32'd1);
    req_valid = '0;
    release_rsp(4'b0010, "t4");

    // Async reset while in WAIT, then a fresh sequence where requester 0 wins over 2
    @(negedge clk);
    req_a[3*NB +: NB] = 8'd5;
    req_b[3*NB +: NB] = 8'd5;
    req_valid[3] = 1'b1;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_busy_wait", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_ctl", {22'b0, busy, mul_start, rsp_valid, req_ready}, 32'd0);
    check("t5_rst_dat", {mul_a, mul_b, rsp_product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_a[2*NB +: NB] = 8'd9;
    req_b[2*NB +: NB] = 8'd9;
    send(0, 8'h81, 8'd2, 4'b0100, lat);
    check("t5_lat", lat, 32'd11);
    check("t5_oh", {28'b0, rsp_valid}, 32'b0001);
    check("t5_prod", {16'b0, rsp_product}, 32'hFF02);
    req_valid = '0;
    release_rsp(4'b0001, "t5");

    // All four held valid after reset: order 0,1,2,3,0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req_a = {8'h80, 8'h7F, 8'hF9, 8'h02};
    req_b = {8'h7F, 8'h7F, 8'h03, 8'h0A};
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n = 0;
      while (rsp_valid == '0 && n < 80) begin
        @(negedge clk); n++;
      end
      check($sformatf("rr%0d_oh", k), {28'b0, rsp_valid}, {28'b0, exp_oh[k]});
      check($sformatf("rr%0d_prod", k), {16'b0, rsp_product}, {16'b0, exp_p[k]});
      if (k == 4) req_valid = '0;
      release_rsp(4'hF, $sformatf("rr%0d", k));
    end

`ifdef MULT_SHARE_TIMEOUT_EN
    // Core never completes: timeout after 32 WAIT cycles
    hang = 1'b1;
    send(0, 8'd3, 8'd5, 4'b0000, lat);
    check("tmo_lat", lat, 32'd35);
    check("tmo_oh", {28'b0, rsp_valid}, 32'b0001);
    check("tmo_err", {31'b0, rsp_err}, 32'd1);
    check("tmo_prod", {16'b0, rsp_product}, 32'd0);
    release_rsp(4'b0001, "tmo");
    check("tmo_err_clr", {31'b0, rsp_err}, 32'd0);
    hang = 1'b0;
`endif

    @(negedge clk);
    check("monitor_handshake_rules", mon_bad, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
